// File: rtl/mux_gate_scheduler.sv
// Round-robin scheduler that evaluates 1-bit gate ops for N requesters on one shared 1-bit mux, in two passes.
// Latency: gnt -> result_valid is 2 cycles; one operation every 3 cycles; requests wait during busy (level-held).

module mux_generic_1bit #(
    parameter int INS = 2,
    parameter int SW  = (INS > 1) ? $clog2(INS) : 1
) (
    input  logic [INS-1:0] w,
    input  logic [SW-1:0]  s,
    output logic           y
);
    assign y = w[s];
endmodule

module mux_gate_scheduler #(
    parameter int N   = 4,
    parameter int INS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         x,
    input  logic [N-1:0]         y,
    input  logic [3*N-1:0]       op,
    output logic [N-1:0]         gnt,
    output logic                 result,
    output logic                 result_valid,
    output logic [$clog2(N)-1:0] result_id,
    output logic                 busy
);
    localparam int IW = $clog2(N);
    localparam int SW = (INS > 1) ? $clog2(INS) : 1;

    typedef enum logic [1:0] {IDLE, P1, P2} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic          cap_x;
    logic          cap_y;
    logic [2:0]    cap_op;
    logic [IW-1:0] cap_id;
    logic          p1;

    logic          win_vld;
    logic [IW-1:0] win_id;
    logic [INS-1:0] mux_w;
    logic [SW-1:0]  mux_s;
    logic [1:0]     w2;
    logic           s1;
    logic           mux_out;

    // Search from ptr upward, wrapping modulo N; first requester found wins.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = IW'(idx);
            end
        end
    end

    // Pass 1 builds a partial term p1; pass 2 combines or inverts it.
    always_comb begin
        w2 = 2'b00;
        s1 = 1'b0;
        case (state)
            P1: begin
                case (cap_op[2:1])
                    2'b00:   begin s1 = cap_x; w2 = {cap_y, cap_x}; end
                    2'b01:   begin s1 = cap_x; w2 = {cap_x, cap_y}; end
                    2'b10:   begin s1 = cap_x; w2 = 2'b01;          end
                    default: begin s1 = cap_y; w2 = 2'b01;          end
                endcase
            end
            P2: begin
                case (cap_op)
                    3'b000, 3'b010, 3'b100: begin s1 = p1;    w2 = 2'b10;        end
                    3'b001, 3'b011, 3'b101: begin s1 = p1;    w2 = 2'b01;        end
                    3'b110:                 begin s1 = cap_x; w2 = {p1, cap_y};  end
                    default:                begin s1 = cap_x; w2 = {cap_y, p1};  end
                endcase
            end
            default: begin
                w2 = 2'b00;
                s1 = 1'b0;
            end
        endcase
        mux_w      = '0;
        mux_w[1:0] = w2;
        mux_s      = SW'(s1);
    end

    mux_generic_1bit #(.INS(INS)) u_mux (
        .w (mux_w),
        .s (mux_s),
        .y (mux_out)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt          <= '0;
            result       <= 1'b0;
            result_valid <= 1'b0;
            result_id    <= '0;
            busy         <= 1'b0;
            cap_x        <= 1'b0;
            cap_y        <= 1'b0;
            cap_op       <= 3'b000;
            cap_id       <= '0;
            p1           <= 1'b0;
        end else begin
            gnt          <= '0;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        cap_x  <= x[win_id];
                        cap_y  <= y[win_id];
                        cap_op <= op[int'(win_id)*3 +: 3];
                        cap_id <= win_id;
                        gnt    <= N'(1) << win_id;
                        ptr    <= (int'(win_id) == N - 1) ? '0 : win_id + 1'b1;
                        busy   <= 1'b1;
                        state  <= P1;
                    end
                end
                P1: begin
                    p1    <= mux_out;
                    state <= P2;
                end
                P2: begin
                    result       <= mux_out;
                    result_valid <= 1'b1;
                    result_id    <= cap_id;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_gate_scheduler.sv
// Directed bench for mux_gate_scheduler (N=4, INS=2): reset, single op, full truth table, round-robin, wrap, reset mid-op.
module tb_mux_gate_scheduler;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [11:0] op;
    logic [3:0]  gnt;
    logic        result;
    logic        result_valid;
    logic [1:0]  result_id;
    logic        busy;

    int tests = 0;
    int fails = 0;

    mux_gate_scheduler #(.N(4), .INS(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .x            (x),
        .y            (y),
        .op           (op),
        .gnt          (gnt),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-written gate table indexed by opcode.
    function automatic logic gate(input logic [2:0] o, input logic a, input logic b);
        case (o)
            3'd0: gate = a & b;
            3'd1: gate = ~(a & b);
            3'd2: gate = a | b;
            3'd3: gate = ~(a | b);
            3'd4: gate = ~a;
            3'd5: gate = a;
            3'd6: gate = a ^ b;
            default: gate = ~(a ^ b);
        endcase
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; req = 4'b1111; x = '0; y = '0; op = '0;
        tick(); tick();
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_rv got=%b exp=0", result_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (result !== 1'b0) begin fails++; $display("FAIL reset_result got=%b exp=0", result); end
        tests++; if (result_id !== 2'd0) begin fails++; $display("FAIL reset_id got=%0d exp=0", result_id); end
        req = 4'b0000;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req = 4'b0001; x = 4'b0001; y = 4'b0001; op = 12'h000;
        tick();
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_p1 got=%b exp=1", busy); end
        req = 4'b0000;
        tick();
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL single_gnt_pulse got=%b exp=0000", gnt); end
        tests++; if (busy !== 1'b1 || result_valid !== 1'b0) begin
            fails++; $display("FAIL single_p2 busy=%b rv=%b exp busy=1 rv=0", busy, result_valid); end
        tick();
        tests++; if (result_valid !== 1'b1 || result !== 1'b1 || result_id !== 2'd0) begin
            fails++; $display("FAIL single_result rv=%b res=%b id=%0d exp rv=1 res=1 id=0", result_valid, result, result_id); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        tick();
        tests++; if (result_valid !== 1'b0 || result !== 1'b1) begin
            fails++; $display("FAIL single_hold rv=%b res=%b exp rv=0 res=1", result_valid, result); end
    endtask

    task automatic test_truth_table();
        for (int o = 0; o < 8; o++) begin
            for (int v = 0; v < 4; v++) begin
                logic a, b, e;
                bit   got;
                a = v[1]; b = v[0];
                e = gate(3'(o), a, b);
                req = 4'b0100; x = {1'b0, a, 2'b00}; y = {1'b0, b, 2'b00};
                op = '0; op[8:6] = 3'(o);
                got = 0;
                for (int t = 0; t < 8 && !got; t++) begin
                    tick();
                    if (gnt != 4'b0000) got = 1;
                end
                tests++; if (!got || gnt !== 4'b0100) begin
                    fails++; $display("FAIL truth_gnt op=%0d xy=%0d got=%b exp=0100", o, v, gnt); end
                // Scramble operands while busy; the captured values must be used.
                req = 4'b0000; x = ~x; y = ~y; op = ~op;
                tick(); tick();
                tests++; if (result_valid !== 1'b1 || result !== e || result_id !== 2'd2) begin
                    fails++; $display("FAIL truth op=%0d x=%b y=%b rv=%b res=%b id=%0d exp res=%b id=2",
                                      o, a, b, result_valid, result, result_id, e); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        reset_n = 1'b0; req = 4'b0000;
        tick(); tick();
        reset_n = 1'b1; req = 4'b1111; x = 4'b1010; y = 4'b0110; op = 12'hFAC;
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++; if (gnt !== exp_seq[i]) begin
                fails++; $display("FAIL rr_gnt%0d got=%b exp=%b", i, gnt, exp_seq[i]); end
            if (i < 4) begin
                tick(); tick();
                tests++; if (gnt !== 4'b0000 || result_valid !== 1'b1) begin
                    fails++; $display("FAIL rr_gap%0d gnt=%b rv=%b exp gnt=0000 rv=1", i, gnt, result_valid); end
                tick();
            end
        end
    endtask

    task automatic test_wrap();
        bit got;
        req = 4'b0100;
        got = 0;
        for (int t = 0; t < 8 && !got; t++) begin
            tick();
            if (gnt != 4'b0000) got = 1;
        end
        tests++; if (!got || gnt !== 4'b0100) begin fails++; $display("FAIL wrap_pre got=%b exp=0100", gnt); end
        req = 4'b0101;
        got = 0;
        for (int t = 0; t < 8 && !got; t++) begin
            tick();
            if (gnt != 4'b0000) got = 1;
        end
        tests++; if (!got || gnt !== 4'b0001) begin fails++; $display("FAIL wrap_gnt got=%b exp=0001", gnt); end
        req = 4'b0000;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_op();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1; req = 4'b0010;
        tick();
        tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL mid_gnt1 got=%b exp=0010", gnt); end
        req = 4'b1111;
        tick();
        reset_n = 1'b0;
        tick();
        tests++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL mid_abort rv=%b busy=%b exp rv=0 busy=0", result_valid, busy); end
        reset_n = 1'b1;
        tick();
        tests++; if (gnt !== 4'b0001 || result_valid !== 1'b0) begin
            fails++; $display("FAIL mid_next gnt=%b rv=%b exp gnt=0001 rv=0", gnt, result_valid); end
        req = 4'b0000;
        tick(); tick(); tick();
    endtask

    // gnt must be zero or one-hot in every cycle.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && !$onehot0(gnt)) begin
            fails++;
            $display("FAIL gnt_onehot got=%b exp=zero-or-onehot", gnt);
        end
    end

    initial begin
        test_reset();
        test_single();
        test_truth_table();
        test_round_robin();
        test_wrap();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout sim_time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end
endmodule
